// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transfer scheduler.
// The optional watchdog is enabled by defining SPI_SCHED_TIMEOUT_EN.
package spi_sched_pkg;

  localparam int DATA_W = 10;
  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    GAP
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Four-way round-robin arbiter: scans upward from the pointer, wrapping 3 -> 0.
// The pointer moves past the winner only when the scheduler accepts the grant.
module spi_rr_arbiter
  import spi_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  output logic [N_REQ-1:0] gnt_o,
  output id_t              id_o,
  output logic             valid_o
);

  id_t  ptr_q;
  id_t  idx;
  logic found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= id_o + id_t'(1);
    end
  end

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr_q + id_t'(k);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        id_o       = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one SPI master among four requesters; requester n always talks to slave n.
// Define SPI_SCHED_TIMEOUT_EN to add a watchdog that aborts a transfer stuck in WAIT.
//
//  state | meaning
//  IDLE  | no transfer; arbitrate pending requests
//  SETUP | slave selected, settling before the start pulse
//  START | one-cycle start pulse to the SPI master
//  WAIT  | waiting for the master's receive-complete
//  GAP   | all selects released before the next grant
module spi_xfer_scheduler
  import spi_sched_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 512
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic [DATA_W-1:0]       m_data_in,
  output logic                    m_tx_start,
  output logic [N_REQ-1:0]        m_ss_n,
  input  logic [DATA_W-1:0]       m_data_out,
  input  logic                    m_rx_done,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic [ID_W-1:0]         resp_id,
  output logic                    resp_err
);

  localparam int CNT_MAX = max_int(max_int(SETUP_CYC, GAP_CYC), TIMEOUT_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ss_n_q, ss_n_d;
  logic [DATA_W-1:0]   data_q, data_d;
  id_t                 id_q, id_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  id_t                 resp_id_q, resp_id_d;

  logic [N_REQ-1:0]    arb_gnt;
  id_t                 arb_id;
  logic                arb_valid;
  logic                arb_adv;

  spi_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req),
    .adv_i   (arb_adv),
    .gnt_o   (arb_gnt),
    .id_o    (arb_id),
    .valid_o (arb_valid)
  );

`ifdef SPI_SCHED_TIMEOUT_EN
  logic resp_err_q, resp_err_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      ss_n_q       <= '1;
      data_q       <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      ss_n_q       <= ss_n_d;
      data_q       <= data_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
`ifdef SPI_SCHED_TIMEOUT_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = '0;
    ss_n_d       = ss_n_q;
    data_d       = data_q;
    id_d         = id_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    arb_adv      = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          data_d  = req_data[arb_id*DATA_W +: DATA_W];
          id_d    = arb_id;
          ss_n_d  = ~arb_gnt;
          cnt_d   = CNT_W'(SETUP_CYC);
          arb_adv = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_d = START;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      START: begin
        cnt_d   = CNT_W'(TIMEOUT_CYC - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the watchdog's last cycle still counts as success.
        if (m_rx_done) begin
          resp_valid_d = 1'b1;
          resp_data_d  = m_data_out;
          resp_id_d    = id_q;
          ss_n_d       = '1;
          cnt_d        = CNT_W'(GAP_CYC - 1);
          state_d      = GAP;
`ifdef SPI_SCHED_TIMEOUT_EN
          resp_err_d   = 1'b0;
        end else if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_id_d    = id_q;
          resp_err_d   = 1'b1;
          ss_n_d       = '1;
          cnt_d        = CNT_W'(GAP_CYC - 1);
          state_d      = GAP;
        end else begin
          cnt_d        = cnt_q - CNT_W'(1);
`endif
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign m_data_in  = data_q;
  assign m_tx_start = (state_q == START);
  assign m_ss_n     = ss_n_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
`ifdef SPI_SCHED_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule
